instr_prefetch_queue: RTL and testbench

- Fetch front-end that sits directly upstream of the pipeline's IF/ID register.
- Issues word fetches to a variable-latency instruction memory using a req/ack handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents one {PC, instruction} per cycle to the IF stage.
- Branch/jump redirects from the MEM stage flush the queue and discard any in-flight fetch.

---
 rtl/instr_prefetch_queue.sv | 126 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: req/ack fetch engine feeding a DEPTH-entry {pc, instr} FIFO.
// Optional feature macro PREFETCH_HALT_EN parks fetching after a FENCE/SYSTEM opcode is queued.
module instr_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   if_ready,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_instr,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int          PW   = $clog2(DEPTH);
  localparam int          CW   = PW + 1;
  localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, mem_addr_d, redirect_pc_al;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW:0]   count_after;
  logic          halted_q, halted_d;
  logic          push, pop, halt_hit, hold_addr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
  assign if_valid       = (count_q != '0);
  assign push           = (state_q == S_REQ) && mem_ack && !redirect;
  assign pop            = if_valid && if_ready && !redirect;
  assign count_after    = (CW + 1)'(count_q) + (CW + 1)'(push) - (CW + 1)'(pop);

`ifdef PREFETCH_HALT_EN
  assign halt_hit = (mem_rdata[6:0] == 7'b0001111) || (mem_rdata[6:0] == 7'b1110011);
`else
  assign halt_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect)                                 fetch_pc_d = redirect_pc_al;
        else if (!halted_q && (count_after < FULL))   state_d    = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          // The outstanding handshake must still complete; its data is dropped.
          fetch_pc_d = redirect_pc_al;
          state_d    = mem_ack ? S_IDLE : S_DISCARD;
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if ((count_after >= FULL) || halt_hit) state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (redirect) fetch_pc_d = redirect_pc_al;
        if (mem_ack)  state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The bus address stays frozen until the pending request is acknowledged.
  assign hold_addr  = (state_d == S_DISCARD) || ((state_q == S_REQ) && !mem_ack);
  assign mem_addr_d = hold_addr ? mem_addr : fetch_pc_d;
  assign halted_d   = redirect ? 1'b0 : (halted_q || (push && halt_hit));

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr   <= RESET_PC;
      mem_req    <= 1'b0;
      halted_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr   <= mem_addr_d;
      mem_req    <= (state_d != S_IDLE);
      halted_q   <= halted_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_after[CW-1:0];
      end
    end
  end

  // NOTE: queue storage has no reset; if_valid gates every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  assign if_pc    = if_valid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign if_instr = if_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
  assign q_count  = count_q;

  // Credit logic must never let occupancy pass DEPTH.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) count_after <= FULL);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: queue-based reference model plus directed checks.
// Expectations for the halt scenario follow PREFETCH_HALT_EN when it is defined.
module tb_instr_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0033;
`ifdef PREFETCH_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_ack, redirect, if_ready, if_valid;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, if_pc, if_instr;
  logic [2:0]  q_count;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 0;
  int          wcnt  = 0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_pc = 32'h0, ovr_word = 32'h0;

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        mq[$];
  bit          m_out, m_stale, m_halted;
  logic [31:0] m_addr, m_next;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_ready(if_ready), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: address bits above an ALU opcode, with one optional overridden word.
  function automatic logic [31:0] img(input logic [31:0] a);
    if (ovr_en && a == ovr_pc) return ovr_word;
    return {a[24:0], 7'h13};
  endfunction

  function automatic bit is_halt(input logic [31:0] w);
    return HALT && (w[6:0] == 7'b0001111 || w[6:0] == 7'b1110011);
  endfunction

  // Responder: acknowledges a request after 'lat' wait cycles, driven on the falling edge.
  initial begin
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ack) wcnt = 0;
      if (!rst || !mem_req) begin
        mem_ack = 1'b0; wcnt = 0;
      end else if (wcnt >= lat) begin
        mem_ack = 1'b1; mem_rdata = img(mem_addr);
      end else begin
        mem_ack = 1'b0; wcnt++;
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    m_out = 1'b0; m_stale = 1'b0; m_halted = 1'b0; m_addr = 32'h0; m_next = 32'h0;
  endtask

  // Reference model: outstanding-request flag, stale flag and a queue of {pc, instr}.
  task automatic model_step();
    bit hs, live;
    hs   = m_out && mem_ack;
    live = hs && !m_stale && !redirect;
    if (redirect) begin
      mq.delete(); m_next = redirect_pc & 32'hFFFF_FFFC; m_halted = 1'b0;
    end else begin
      if (mq.size() != 0 && if_ready) void'(mq.pop_front());
      if (live) begin
        mq.push_back('{pc: m_addr, instr: mem_rdata});
        m_next = m_addr + 32'd4;
        if (is_halt(mem_rdata)) m_halted = 1'b1;
      end
    end
    if (m_out && !hs) begin
      if (redirect) m_stale = 1'b1;
    end else if (hs) begin
      m_stale = 1'b0;
      if (live && !m_halted && mq.size() < DEPTH) m_addr = m_next;
      else m_out = 1'b0;
    end else if (!redirect && !m_halted && mq.size() < DEPTH) begin
      m_out = 1'b1; m_addr = m_next;
    end
  endtask

  // Per-cycle compare of every DUT output against the model, then advance the model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk); #2;
      if (!rst) model_reset();
      check("m_req", 32'(mem_req), 32'(m_out));
      if (m_out) check("m_addr", mem_addr, m_addr);
      check("m_valid", 32'(if_valid), 32'(mq.size() != 0));
      check("m_count", 32'(q_count), 32'(mq.size()));
      if (mq.size() != 0) begin
        check("m_pc", if_pc, mq[0].pc);
        check("m_instr", if_instr, mq[0].instr);
      end else begin
        check("m_nop", if_instr, NOP);
      end
      if (rst) model_step();
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
  endtask

  initial begin
    bit found;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, NOP);
    check("rst_count", 32'(q_count), 32'h0);

    // Zero-wait streaming from reset.
    tick(); rst = 1'b1; if_ready = 1'b1;
    tick();
    check("s_req", 32'(mem_req), 32'h1);
    check("s_addr0", mem_addr, 32'h0);
    check("s_valid0", 32'(if_valid), 32'h0);
    tick(); check("s_pc0", if_pc, 32'h0);  check("s_in0", if_instr, 32'h0000_0013);
    tick(); check("s_pc4", if_pc, 32'h4);  check("s_in4", if_instr, 32'h0000_0213);
    tick(); check("s_pc8", if_pc, 32'h8);  check("s_in8", if_instr, 32'h0000_0413);
    tick(); check("s_pcc", if_pc, 32'hC);  check("s_inc", if_instr, 32'h0000_0613);

    // Stalled IF: fill to DEPTH, then one pop restarts fetching at 16.
    if_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    check("f_count", 32'(q_count), 32'h4);
    check("f_req", 32'(mem_req), 32'h0);
    check("f_head", if_pc, 32'h0);
    repeat (2) tick();
    check("f_req_hold", 32'(mem_req), 32'h0);
    if_ready = 1'b1;
    tick(); if_ready = 1'b0;
    check("f_req_up", 32'(mem_req), 32'h1);
    check("f_addr16", mem_addr, 32'h10);
    check("f_pop_pc", if_pc, 32'h4);
    check("f_count3", 32'(q_count), 32'h3);

    // Slow memory with a redirect in the first wait cycle.
    lat = 3; if_ready = 1'b1;
    do_reset();
    tick(); redirect = 1'b1; redirect_pc = 32'h40;
    tick(); redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("d_req_held", 32'(mem_req), 32'h1);
      check("d_addr_old", mem_addr, 32'h0);
      check("d_empty", 32'(if_valid), 32'h0);
      tick();
    end
    check("d_req_off", 32'(mem_req), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) found = 1'b1; else tick();
    end
    check("d_found", 32'(found), 32'h1);
    check("d_first_pc", if_pc, 32'h40);

    // Redirect coinciding with an ack, misaligned target.
    lat = 0; if_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_req && mem_ack && q_count != 3'd0) found = 1'b1; else tick();
    end
    check("r_found", 32'(found), 32'h1);
    redirect = 1'b1; redirect_pc = 32'h103;
    tick(); redirect = 1'b0;
    check("r_count", 32'(q_count), 32'h0);
    check("r_valid", 32'(if_valid), 32'h0);
    check("r_nop", if_instr, 32'h0000_0033);
    check("r_addr", mem_addr, 32'h100);
    tick();
    check("r_req", 32'(mem_req), 32'h1);
    check("r_addr2", mem_addr, 32'h100);

    // Asynchronous reset in the middle of a fetch with three entries queued.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (q_count == 3'd3 && mem_req) found = 1'b1; else tick();
    end
    check("a_found", 32'(found), 32'h1);
    rst = 1'b0;
    #1;
    check("a_req", 32'(mem_req), 32'h0);
    check("a_addr", mem_addr, 32'h0);
    check("a_count", 32'(q_count), 32'h0);
    check("a_valid", 32'(if_valid), 32'h0);
    check("a_pc", if_pc, 32'h0);
    check("a_instr", if_instr, NOP);
    tick(); rst = 1'b1; lat = 0; if_ready = 1'b1;
    tick(); check("a_restart", mem_addr, 32'h0); check("a_req2", 32'(mem_req), 32'h1);
    tick(); check("a_pc0", if_pc, 32'h0);

    // FENCE at PC 8: halts fetching when the feature is built in.
    ovr_en = 1'b1; ovr_pc = 32'h8; ovr_word = 32'h0000_000F;
    do_reset();
    tick(); check("h_addr0", mem_addr, 32'h0);
    tick(); check("h_pc0", if_pc, 32'h0);
    tick(); check("h_pc4", if_pc, 32'h4);
    tick(); check("h_pc8", if_pc, 32'h8);
    check("h_fence", if_instr, 32'h0000_000F);
    check("h_req_a", 32'(mem_req), 32'(!HALT));
    tick(); check("h_req_b", 32'(mem_req), 32'(!HALT)); check("h_drain", 32'(if_valid), 32'(!HALT));
    tick(); check("h_req_c", 32'(mem_req), 32'(!HALT));
    tick(); check("h_req_d", 32'(mem_req), 32'(!HALT));
    redirect = 1'b1; redirect_pc = 32'h20;
    tick(); redirect = 1'b0;
    check("h_req_e", 32'(mem_req), 32'h0);
    check("h_count", 32'(q_count), 32'h0);
    tick(); check("h_resume", 32'(mem_req), 32'h1); check("h_addr20", mem_addr, 32'h20);
    ovr_en = 1'b0;

    // fetch_pc wraps from the top of the address space to zero.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (if_valid) found = 1'b1; else tick();
    end
    check("w_found", 32'(found), 32'h1);
    check("w_pc_top", if_pc, 32'hFFFF_FFFC);
    check("w_in_top", if_instr, 32'hFFFF_FE13);
    tick();
    check("w_pc_zero", if_pc, 32'h0);
    check("w_in_zero", if_instr, 32'h0000_0013);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule
